// File: rtl/pkt_demux_4pri.sv
// 1-to-4 packet demultiplexer: priority decode (a>b>c>d, sel_b active-low) on the
// first beat, destination locked until in_last, one registered output stage.
// Optional per-sink packet counters are built when PKT_CNT_EN is defined.
module pkt_demux_4pri #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              sel_a,
   input  logic              sel_b,
   input  logic              sel_c,
   output logic [3:0]        out_valid,
   input  logic [3:0]        out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [CNT_W-1:0]  pkt_cnt_a,
   output logic [CNT_W-1:0]  pkt_cnt_b,
   output logic [CNT_W-1:0]  pkt_cnt_c,
   output logic [CNT_W-1:0]  pkt_cnt_d
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   localparam logic [1:0] DEST_A = 2'd0;
   localparam logic [1:0] DEST_B = 2'd1;
   localparam logic [1:0] DEST_C = 2'd2;
   localparam logic [1:0] DEST_D = 2'd3;

   logic [0:0] state;
   logic [1:0] lock_dest;
   logic [1:0] dec_dest;
   logic [1:0] next_dest;
   logic       stg_vld;
   logic [1:0] stg_dest;
   logic       accept;
   logic       drain;

   always_comb begin
      dec_dest = DEST_D;
      if (sel_a)
         dec_dest = DEST_A;
      else if (!sel_b)
         dec_dest = DEST_B;
      else if (sel_c)
         dec_dest = DEST_C;
   end

   // First beat of a packet routes by decode; later beats follow the lock.
   assign next_dest = (state == IDLE) ? dec_dest : lock_dest;

   assign drain    = stg_vld && out_ready[stg_dest];
   assign in_ready = !stg_vld || out_ready[stg_dest];
   assign accept   = in_valid && in_ready;

   assign out_valid = stg_vld ? (4'b0001 << stg_dest) : 4'b0000;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lock_dest <= DEST_A;
      end else if (accept) begin
         if (state == IDLE) begin
            if (!in_last) begin
               state     <= BUSY;
               lock_dest <= dec_dest;
            end
         end else if (in_last) begin
            state <= IDLE;
         end
      end
   end

   // Accept takes precedence over drain so a simultaneous drain+accept reloads.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_vld  <= 1'b0;
         stg_dest <= DEST_A;
         out_data <= '0;
         out_last <= 1'b0;
      end else if (accept) begin
         stg_vld  <= 1'b1;
         stg_dest <= next_dest;
         out_data <= in_data;
         out_last <= in_last;
      end else if (drain) begin
         stg_vld <= 1'b0;
      end
   end

`ifdef PKT_CNT_EN
   logic [CNT_W-1:0] cnt [4];

   // Counters saturate rather than wrap so a long run never reports a small count.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (out_valid[i] && out_ready[i] && out_last && (cnt[i] != {CNT_W{1'b1}}))
               cnt[i] <= cnt[i] + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign pkt_cnt_a = cnt[0];
   assign pkt_cnt_b = cnt[1];
   assign pkt_cnt_c = cnt[2];
   assign pkt_cnt_d = cnt[3];
`else
   assign pkt_cnt_a = '0;
   assign pkt_cnt_b = '0;
   assign pkt_cnt_c = '0;
   assign pkt_cnt_d = '0;
`endif

endmodule

// File: tb/tb_pkt_demux_4pri.sv
// Scoreboard bench for pkt_demux_4pri: stimulus pushes expected beats, a monitor
// pops and compares on every sink handshake. Define PKT_CNT_EN to test counters.
module tb_pkt_demux_4pri;

   localparam int DATA_W = 8;
`ifdef PKT_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              sel_a;
   logic              sel_b;
   logic              sel_c;
   logic [3:0]        out_valid;
   logic [3:0]        out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic [CNT_W-1:0]  pkt_cnt_a;
   logic [CNT_W-1:0]  pkt_cnt_b;
   logic [CNT_W-1:0]  pkt_cnt_c;
   logic [CNT_W-1:0]  pkt_cnt_d;

   typedef struct packed {
      logic [1:0]        dest;
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pkt_demux_4pri #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b), .pkt_cnt_c(pkt_cnt_c), .pkt_cnt_d(pkt_cnt_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: sample at negedge, pop one expected beat per sink handshake.
   always @(negedge clk) begin
      if (!rst && out_valid != 4'b0000) begin
         check("out_valid onehot", 32'($countones(out_valid)), 32'd1);
         for (int i = 0; i < 4; i++) begin
            if (out_valid[i] && out_ready[i]) begin
               if (sb.size() == 0) begin
                  check("unexpected beat on sink", 32'(i), 32'hFFFF_FFFF);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check("beat dest", 32'(i), 32'(e.dest));
                  check("beat data", 32'(out_data), 32'(e.data));
                  check("beat last", 32'(out_last), 32'(e.last));
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] data,
                                input logic last, input logic [1:0] dest, output int waits);
      exp_t e;
      sel_a    = sel[2];
      sel_b    = sel[1];
      sel_c    = sel[0];
      in_data  = data;
      in_last  = last;
      in_valid = 1'b1;
      waits    = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            e.dest = dest;
            e.data = data;
            e.last = last;
            sb.push_back(e);
            @(posedge clk);
            #1;
            return;
         end
         waits++;
         @(posedge clk);
         #1;
      end
      check("accept timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst      = 1'b1;
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic checkOutput(input string tag);
      check({tag, " out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      check({tag, " cnt_a"}, 32'(pkt_cnt_a), 32'd0);
      check({tag, " cnt_b"}, 32'(pkt_cnt_b), 32'd0);
      check({tag, " cnt_c"}, 32'(pkt_cnt_c), 32'd0);
      check({tag, " cnt_d"}, 32'(pkt_cnt_d), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int w;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      sel_a     = 1'b0;
      sel_b     = 1'b1;
      sel_c     = 1'b0;
      out_ready = 4'hF;

      // 1: reset, then reset again with the stage full mid-packet
      do_reset(2);
      checkOutput("reset");
      check("reset out_data", 32'(out_data), 32'd0);
      check("reset out_last", 32'(out_last), 32'd0);
      out_ready = 4'h0;
      applyStimulus(3'b011, 8'hA5, 1'b0, 2'd2, w);
      check("stage full before reset", 32'(out_valid), 32'b0100);
      check("in_ready low when stalled", 32'(in_ready), 32'd0);
      do_reset(2);
      checkOutput("mid-stream reset");
      out_ready = 4'hF;

      // 2: priority decode, one single-beat packet each
      applyStimulus(3'b100, 8'h01, 1'b1, 2'd0, w);
      check("decode a latency", 32'(out_valid), 32'b0001);
      check("decode a data", 32'(out_data), 32'h01);
      applyStimulus(3'b001, 8'h02, 1'b1, 2'd1, w);
      check("decode b latency", 32'(out_valid), 32'b0010);
      applyStimulus(3'b011, 8'h03, 1'b1, 2'd2, w);
      check("decode c latency", 32'(out_valid), 32'b0100);
      applyStimulus(3'b010, 8'h04, 1'b1, 2'd3, w);
      check("decode d latency", 32'(out_valid), 32'b1000);
      check("decode d data", 32'(out_data), 32'h04);
      idle(2);

      // 3: destination lock survives changing selects
      applyStimulus(3'b100, 8'h10, 1'b0, 2'd0, w);
      applyStimulus(3'b001, 8'h11, 1'b0, 2'd0, w);
      applyStimulus(3'b001, 8'h12, 1'b0, 2'd0, w);
      applyStimulus(3'b001, 8'h13, 1'b1, 2'd0, w);
      check("lock last beat sink", 32'(out_valid), 32'b0001);
      idle(2);

      // 4: backpressure on sink c, then full-rate drain
      out_ready = 4'b1011;
      applyStimulus(3'b011, 8'h20, 1'b0, 2'd2, w);
      in_data  = 8'h21;
      in_last  = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp in_ready", 32'(in_ready), 32'd0);
         check("bp data held", 32'(out_data), 32'h20);
         check("bp out_valid", 32'(out_valid), 32'b0100);
         @(posedge clk);
         #1;
      end
      out_ready = 4'hF;
      applyStimulus(3'b100, 8'h21, 1'b0, 2'd2, w);
      check("bp resume wait 0x21", 32'(w), 32'd0);
      applyStimulus(3'b100, 8'h22, 1'b0, 2'd2, w);
      check("bp resume wait 0x22", 32'(w), 32'd0);
      applyStimulus(3'b100, 8'h23, 1'b1, 2'd2, w);
      check("bp resume wait 0x23", 32'(w), 32'd0);
      idle(2);

      // 5: reset after beat 2 of 5 to d; next beat re-decodes to a
      applyStimulus(3'b010, 8'h30, 1'b0, 2'd3, w);
      applyStimulus(3'b010, 8'h31, 1'b0, 2'd3, w);
      do_reset(1);
      check("post-reset out_valid", 32'(out_valid), 32'd0);
      applyStimulus(3'b100, 8'h40, 1'b1, 2'd0, w);
      check("re-decode sink", 32'(out_valid), 32'b0001);
      check("re-decode data", 32'(out_data), 32'h40);
      idle(2);

      // 6: five packets to b; counters saturate at 3 when built
      do_reset(1);
      for (int k = 0; k < 5; k++)
         applyStimulus(3'b000, 8'(8'h50 + k), 1'b1, 2'd1, w);
      idle(3);
      check("cnt_a", 32'(pkt_cnt_a), 32'd0);
`ifdef PKT_CNT_EN
      check("cnt_b saturated", 32'(pkt_cnt_b), 32'd3);
`else
      check("cnt_b disabled", 32'(pkt_cnt_b), 32'd0);
`endif
      check("cnt_c", 32'(pkt_cnt_c), 32'd0);
      check("cnt_d", 32'(pkt_cnt_d), 32'd0);

      idle(3);
      check("scoreboard drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
